// File: rtl/payload_crc_gen.sv
// Transmit-side payload forwarder: passes PAYLOAD_BYTES bytes through a
// registered output stage and appends the Ethernet CRC-32, LSB byte first.
module payload_crc_gen #(
  parameter int PAYLOAD_BYTES = 46
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_start,
  input  logic [7:0] i_in_data,
  input  logic       i_in_valid,
  output logic       o_in_ready,
  output logic [7:0] o_out_data,
  output logic       o_out_valid,
  input  logic       i_out_ready,
  output logic       o_out_last,
  output logic       o_busy,
  output logic       o_done
);

  localparam logic [7:0] LAST_IDX = 8'(PAYLOAD_BYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_CRC, S_FLUSH} state_t;

  state_t      r_state, w_next;
  logic [7:0]  r_cnt;
  logic [1:0]  r_crc_idx;
  logic [31:0] r_crc;
  logic [7:0]  r_out_data;
  logic        r_out_valid, r_out_last, r_done;
  logic        w_free, w_in_xfer, w_out_xfer;
  logic [31:0] w_crc_fin;
  logic [7:0]  w_crc_byte;

  // Reflected CRC-32, one byte per cycle, data bits consumed LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  assign w_free     = !r_out_valid || i_out_ready;
  assign o_in_ready = (r_state == S_PAYLOAD) && w_free;
  assign w_in_xfer  = i_in_valid && o_in_ready;
  assign w_out_xfer = r_out_valid && i_out_ready;
  assign w_crc_fin  = ~r_crc;
  assign w_crc_byte = w_crc_fin[8*r_crc_idx +: 8];

  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_out_last  = r_out_last;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = r_done;

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (i_start) w_next = S_PAYLOAD;
      S_PAYLOAD: if (w_in_xfer && r_cnt == LAST_IDX) w_next = S_CRC;
      S_CRC:     if (w_free && r_crc_idx == 2'd3) w_next = S_FLUSH;
      S_FLUSH:   if (w_out_xfer) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_cnt       <= 8'd0;
      r_crc_idx   <= 2'd0;
      r_crc       <= 32'hFFFFFFFF;
      r_out_data  <= 8'd0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_cnt     <= 8'd0;
            r_crc     <= 32'hFFFFFFFF;
            r_crc_idx <= 2'd0;
          end
        end
        S_PAYLOAD: begin
          if (w_in_xfer) begin
            r_out_data  <= i_in_data;
            r_out_valid <= 1'b1;
            r_crc       <= crc32_byte(r_crc, i_in_data);
            r_cnt       <= r_cnt + 8'd1;
            r_crc_idx   <= 2'd0;
          end else if (w_out_xfer) begin
            r_out_valid <= 1'b0;
          end
        end
        S_CRC: begin
          if (w_free) begin
            r_out_data  <= w_crc_byte;
            r_out_valid <= 1'b1;
            r_out_last  <= (r_crc_idx == 2'd3);
            r_crc_idx   <= r_crc_idx + 2'd1;
          end
        end
        S_FLUSH: begin
          if (w_out_xfer) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
